// File: rtl/abc_seq_pkg.sv
// -----------------------------------------------------------------------------
// abc_seq_pkg
// Shared types and default widths for the a -> b -> c -> !c stimulus driver.
//   abc_seq_state_t : FSM state encoding used by abc_seq_driver
//   CNT_W_DEF       : default width of launch delay / c length / gap counters
//   REP_W_DEF       : default width of repetition count and iteration index
// -----------------------------------------------------------------------------
package abc_seq_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int REP_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SA     = 3'd2,
        ST_SB     = 3'd3,
        ST_SC     = 3'd4,
        ST_TAIL   = 3'd5,
        ST_GAP    = 3'd6
    } abc_seq_state_t;

endpackage

// File: rtl/abc_seq_cnt.sv
// -----------------------------------------------------------------------------
// abc_seq_cnt
// Loadable down-counter with terminal-count flag. The driver loads it with
// (length - 1) on entry to a timed state and leaves the state when tc_o is set.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   load_i          load load_val_i this cycle (has priority over dec_i)
//   load_val_i      value to load (terminal-count offset, i.e. length - 1)
//   dec_i           decrement; the count holds at zero
//   tc_o            count has reached zero
// -----------------------------------------------------------------------------
module abc_seq_cnt
    import abc_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= CNT_ZERO;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != CNT_ZERO)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/abc_seq_driver.sv
// -----------------------------------------------------------------------------
// abc_seq_driver
// Emits the pulse sequence a, b, c (held c_len cycles), all-low tail, repeated
// reps times with gap low cycles between sequences, after a launch delay.
// Configuration is latched on an accepted start; later input changes are
// ignored until the next start.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   start_i         one-cycle request, accepted only while idle and not busy
//   launch_dly_i    idle cycles between start and the first a
//   c_len_i         cycles c is high; 0 suppresses c entirely
//   gap_i           all-low cycles between sequences
//   reps_i          number of sequences (0 behaves as 1)
//   err_inject_i    (only with ABC_SEQ_DRV_ERR_INJECT_EN) drop b in iteration 0
//   busy_o          run active
//   done_o          pulse in the final tail cycle
//   a_o, b_o, c_o   driven sequence
//   iter_o          index of the sequence currently being driven
// Build option: define ABC_SEQ_DRV_ERR_INJECT_EN to add err_inject_i.
//
// All outputs are registered decodes of the FSM state, so the driven sequence
// appears one cycle after the state that produces it. busy_o covers both the
// FSM being active and that final output cycle.
// -----------------------------------------------------------------------------
module abc_seq_driver
    import abc_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] launch_dly_i,
    input  logic [CNT_W-1:0] c_len_i,
    input  logic [CNT_W-1:0] gap_i,
    input  logic [REP_W-1:0] reps_i,
`ifdef ABC_SEQ_DRV_ERR_INJECT_EN
    input  logic             err_inject_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic [REP_W-1:0] iter_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

    abc_seq_state_t   state_q, state_d;

    logic [CNT_W-1:0] c_len_q;
    logic [CNT_W-1:0] gap_q;
    logic [REP_W-1:0] reps_q;      // effective repetition count, never 0
    logic [REP_W-1:0] iter_q, iter_d;

    logic             start_acc_s;
    logic             last_s;
    logic             supp_b_s;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_dec_s;
    logic             cnt_tc_s;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             c_q, c_d;
    logic [REP_W-1:0] iter_o_q, iter_o_d;

    // A start is honoured only once the output pipeline has drained too,
    // so a run is never re-triggered while busy_o is still high.
    assign start_acc_s = start_i && (state_q == ST_IDLE) && !busy_q;

    // Widened compare so iter + 1 cannot wrap for the largest reps value.
    assign last_s = (({1'b0, iter_q} + {1'b0, REP_ONE}) == {1'b0, reps_q});

`ifdef ABC_SEQ_DRV_ERR_INJECT_EN
    logic err_q;

    // Error-inject flag latched with the rest of the configuration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (start_acc_s) begin
            err_q <= err_inject_i;
        end else begin
            err_q <= err_q;
        end
    end

    assign supp_b_s = err_q && (iter_q == REP_ZERO);
`else
    assign supp_b_s = 1'b0;
`endif

    // Shared timer for LAUNCH, SC and GAP; reloaded on entry to each.
    abc_seq_cnt #(
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .dec_i      (cnt_dec_s),
        .tc_o       (cnt_tc_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic and timer control.
    always_comb begin
        state_d    = state_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = CNT_ZERO;
        cnt_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc_s) begin
                    if (launch_dly_i != CNT_ZERO) begin
                        state_d    = ST_LAUNCH;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = launch_dly_i - CNT_ONE;
                    end else begin
                        state_d = ST_SA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_dec_s = 1'b1;
                if (cnt_tc_s) begin
                    state_d = ST_SA;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_SA: begin
                state_d = ST_SB;
            end
            ST_SB: begin
                if (c_len_q != CNT_ZERO) begin
                    state_d    = ST_SC;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = c_len_q - CNT_ONE;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            ST_SC: begin
                cnt_dec_s = 1'b1;
                if (cnt_tc_s) begin
                    state_d = ST_TAIL;
                end else begin
                    state_d = ST_SC;
                end
            end
            ST_TAIL: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else if (gap_q != CNT_ZERO) begin
                    state_d    = ST_GAP;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = gap_q - CNT_ONE;
                end else begin
                    state_d = ST_SA;
                end
            end
            ST_GAP: begin
                cnt_dec_s = 1'b1;
                if (cnt_tc_s) begin
                    state_d = ST_SA;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Configuration latched on an accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_len_q <= CNT_ZERO;
            gap_q   <= CNT_ZERO;
            reps_q  <= REP_ONE;
        end else if (start_acc_s) begin
            c_len_q <= c_len_i;
            gap_q   <= gap_i;
            reps_q  <= (reps_i == REP_ZERO) ? REP_ONE : reps_i;
        end else begin
            c_len_q <= c_len_q;
            gap_q   <= gap_q;
            reps_q  <= reps_q;
        end
    end

    // Iteration counter next value: cleared on start, stepped leaving a non-final tail.
    always_comb begin
        iter_d = iter_q;
        if (start_acc_s) begin
            iter_d = REP_ZERO;
        end else if ((state_q == ST_TAIL) && !last_s) begin
            iter_d = iter_q + REP_ONE;
        end else begin
            iter_d = iter_q;
        end
    end

    // Iteration counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iter_q <= REP_ZERO;
        end else begin
            iter_q <= iter_d;
        end
    end

    // FSM output decode, registered below.
    always_comb begin
        a_d      = (state_q == ST_SA);
        b_d      = (state_q == ST_SB) && !supp_b_s;
        c_d      = (state_q == ST_SC);
        done_d   = (state_q == ST_TAIL) && last_s;
        busy_d   = (state_d != ST_IDLE) || (state_q != ST_IDLE);
        iter_o_d = iter_q;
        if (start_acc_s) begin
            iter_o_d = REP_ZERO;
        end else begin
            iter_o_d = iter_q;
        end
    end

    // Output registers, aligned one cycle behind the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            c_q      <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            iter_o_q <= REP_ZERO;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            iter_o_q <= iter_o_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign c_o    = c_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign iter_o = iter_o_q;

endmodule

// File: doc/abc_seq_driver.md
# abc_seq_driver

Synthesizable stimulus driver that produces the a → b → c → !c pulse sequence that the assertion benches check, e.g. `a ##1 b ##1 c ##1 !c` sampled on the default clocking edge. On a start pulse it latches its configuration, waits a programmable launch delay, and emits the sequence a programmable number of times with programmable c length and inter-sequence gap. It reports busy and done and sits between bench control logic and the DUT or checker inputs.

## Interface
- CNT_W, 8: width of the launch_dly, c_len and gap counters.
- REP_W, 8: width of reps and iter.
- clk  input  1  sampling clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- launch_dly  input  CNT_W  idle cycles between start and the first a.
- c_len  input  CNT_W  cycles c is held high; 0 means c is never asserted (deliberate-fail pattern).
- gap  input  CNT_W  all-low cycles between consecutive sequences.
- reps  input  REP_W  number of sequences; 0 is treated as 1.
- busy  output  1  high while a run is active.
- done  output  1  one-cycle pulse in the final tail cycle of a run.
- a, b, c  output  1 each  driven sequence.
- iter  output  REP_W  index of the current sequence, starting at 0.

## Operation
- States: IDLE, LAUNCH, SA, SB, SC, TAIL, GAP.
- IDLE:
  - On start, latch launch_dly, c_len, gap and reps.
  - Clear iter.
  - Go to LAUNCH if launch_dly ≠ 0, otherwise go to SA.
- LAUNCH: down-count launch_dly cycles, then go to SA.
- SA: a=1 for 1 cycle, then go to SB.
- SB: b=1 for 1 cycle, then go to SC if c_len ≠ 0, otherwise go to TAIL.
- SC: c=1 for c_len cycles, then go to TAIL.
- TAIL: all outputs low for 1 cycle; this is the !c cycle.
  - If iter+1 = effective reps: assert done and go to IDLE.
  - Otherwise increment iter and go to GAP, or to SA if gap = 0.
- GAP: all outputs low for gap cycles, then go to SA.
- Outputs a, b, c, done and busy are registered state decodes, so they are glitch-free.
- busy is high in every state except IDLE.
- start while busy is ignored; a run is never re-triggered.
- Input changes after start have no effect until the next start.
- Counter arithmetic is unsigned and saturating-free; the latched value minus 1 is the terminal count.
- Reset at any point forces IDLE. All outputs and iter go to 0 immediately (asynchronous), and the run is lost.

## Timing
- Reset values: a=b=c=0, busy=0, done=0, iter=0.
- start sampled high at edge N:
  - busy is high from edge N onward.
  - a is high during the cycle following edge N+launch_dly+1.
- Latency from start to first a: launch_dly+1 cycles.
- Sequence length: 3+c_len cycles, or 3 when c_len=0. b always follows a by exactly 1 cycle.
- done coincides with the last TAIL cycle. busy falls at the next edge.
- The earliest accepted re-start is the cycle after busy falls.

## Configuration
- ABC_SEQ_DRV_ERR_INJECT_EN: when defined, adds input err_inject (1 bit), latched at start.
  - If err_inject was latched high, b is suppressed (held 0) in the SB cycle of iteration 0 only. All timing is otherwise unchanged.
- When the macro is undefined, the port does not exist and b is never suppressed.

## Structure
- Package abc_seq_pkg:
  - state enum type abc_seq_state_t;
  - localparam defaults for CNT_W and REP_W.
- One sub-module, abc_seq_cnt: a loadable CNT_W down-counter with a terminal-count flag. It is shared by the LAUNCH, SC and GAP states, with one instance reloaded at each state entry.
- The FSM and iteration counter live in abc_seq_driver.

## Test plan
- Basic run: launch_dly=0, c_len=1, reps=1, start at edge 10.
  - a high in cycle 11, b in 12, c in 13, all low in 14.
  - done pulses in 14; busy covers 10–14.
- Launch delay plus long c: launch_dly=3, c_len=4, reps=1.
  - a first high 4 cycles after start; c high for exactly 4 consecutive cycles.
  - One low tail cycle, then done.
- Repeats with gap: reps=3, gap=2, c_len=1.
  - Three a pulses spaced 6 cycles apart; iter reads 0, 1, 2.
  - done only after the third tail.
- Corner values: reps=0 and c_len=0.
  - Exactly one a, b, low, low pattern; c never rises; done asserted.
- Control robustness:
  - start pulsed while busy → no effect on timing or iter.
  - rst asserted mid-SC → outputs 0 immediately; a fresh start afterward produces a correct run.
- With ABC_SEQ_DRV_ERR_INJECT_EN and err_inject=1, reps=2:
  - b low in iteration 0 and high in iteration 1.
  - An `expect (a ##1 b ##1 c ##1 !c)` check fails on the first sequence and passes on the second.
